instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Reader and consumer of the 16-entry instruction word bank. Drives the bank index, registers the returned 80-bit word and decodes its fields.
- Issues each operation to the complex ALU datapath, then holds for the word's max-clock budget before fetching the next word.
- Sits between the word bank and the complex ALU/register file. Runs the program from START_ADDR to LAST_ADDR once per start.

Parameters:
- ADDR_W, 4, width of the bank index.
- START_ADDR, 0, first word fetched after start.
- LAST_ADDR, 15, final word; its completion ends the run.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a run; ignored while busy.
- hold  in  1  stalls the FSM in FETCH while high.
- i  out  ADDR_W  bank index (program counter).
- word  in  80  bank word for the current i (combinational from the bank).
- operand  out  64  [63:32] real part, [31:0] imaginary part.
- opr  out  4  ALU opcode.
- issue  out  1  one-cycle pulse: operation starts.
- enrega, enregb  out  1  operand-register load enables; pulse with issue.
- cnsta, cnstb  out  1  constant-select flags; held from ISSUE through WAIT.
- endwreg  out  2  destination register index; held from ISSUE through WAIT.
- wr_en  out  1  one-cycle pulse in the last WAIT cycle: commit the result to endwreg.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the run's completion.
- error  out  1  sticky; set on an illegal opcode; cleared by start or reset.

Behaviour:
- Word layout, MSB first:
  - word[79:16] operand.
  - [15:12] opr.
  - [11:6] maxclock.
  - [5:4] endwreg.
  - [3] enregA, [2] enregB, [1] cnstA, [0] cnstB.
- Reset: state IDLE, i=START_ADDR, all outputs 0, error 0. Reset mid-run aborts immediately; no wr_en or done is emitted.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: on start, go to FETCH, i=START_ADDR, clear error.
- FETCH: if hold=0, register all word fields and go to ISSUE. With hold=1, stay and do not sample.
- ISSUE: one cycle. issue=1, enrega/enregb=registered bits. operand, opr, cnsta, cnstb and endwreg are driven. Load the wait counter with maxclock (maxclock=0 is treated as 1). Go to WAIT.
- WAIT: the counter decrements each cycle. In the cycle with counter==1, wr_en=1. Then:
  - if i==LAST_ADDR, go to DONE;
  - else i<=i+1 and go to FETCH.
- Latency: issue-to-wr_en is exactly maxclock cycles (counted from the cycle after ISSUE). Per-word period is maxclock+2 cycles when hold=0.
- DONE: done=1 for one cycle, i<=START_ADDR, go to IDLE.
- Legal opcodes: 0, 1, 2, 3, 4, 6, 8, 9, 10. Any other opcode:
  - error<=1;
  - the word is skipped: no issue, enrega/enregb or wr_en;
  - FETCH goes directly to the advance/DONE decision.
- i wraps at 2^ADDR_W-1 only if LAST_ADDR is below START_ADDR. The index computation is ADDR_W bits, modulo.
- start while busy has no effect. start in the same cycle as DONE is ignored. start in the following IDLE cycle is accepted.
- Outputs not listed as pulses keep their value until the next ISSUE. They are 0 in IDLE.

Optional Feature:
- Macro: MAXCLK_CHECK_EN.
- When defined: the registered maxclock is compared against the opcode table: 0→1, 1→1, 2→2, 3→2, 4→6, 6→4, 8→1, 9→38, 10→38. On mismatch, error<=1 and the table value is loaded into the counter.
- When undefined: the word's maxclock field is used unchecked.

Decomposition:
- Package instr_pkg: field bit positions, opcode constants, legal-opcode function, opcode→maxclock table function, FSM state enum.
- One sub-module, instr_decode: combinational field split, legality check and (optional) maxclock lookup.

Test Plan:
- Word 0 = {1232, opr 0, maxclk 1, endwreg 0, 1,1,0,1}, pulse start → issue at cycle 3 with operand=1232, enrega=enregb=1, cnstb=1. wr_en 1 cycle later with endwreg=0. Then i=1.
- Word at index 7 with opr 9, maxclk 38 → exactly 38 cycles between issue and wr_en, with endwreg=3 held throughout.
- Full 16-word run with hold=0 → done pulses once after index 15; busy falls the next cycle; i returns to 0.
- Inject opr 5 at index 2 → error=1, no issue or wr_en for index 2, index 3 is fetched next. A subsequent start clears error.
- Assert reset during WAIT of index 4 → next cycle busy=0, all outputs 0, no wr_en. Assert hold=1 for 5 cycles in FETCH → issue is delayed by exactly 5 cycles.
- With MAXCLK_CHECK_EN, a word with opr 4 and maxclk 2 → error=1 and the wr_en gap is 6 cycles.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types for the instruction sequencer: 80-bit word layout, opcode set,
// opcode legality and the opcode-to-max-clock budget table.
package instr_pkg;

  localparam int WORD_W = 80;

  // MSB-first field map of one instruction word.
  typedef struct packed {
    logic [63:0] operand;
    logic [3:0]  opr;
    logic [5:0]  maxclock;
    logic [1:0]  endwreg;
    logic        enrega;
    logic        enregb;
    logic        cnsta;
    logic        cnstb;
  } word_t;

  localparam logic [3:0] OP_0  = 4'd0;
  localparam logic [3:0] OP_1  = 4'd1;
  localparam logic [3:0] OP_2  = 4'd2;
  localparam logic [3:0] OP_3  = 4'd3;
  localparam logic [3:0] OP_4  = 4'd4;
  localparam logic [3:0] OP_6  = 4'd6;
  localparam logic [3:0] OP_8  = 4'd8;
  localparam logic [3:0] OP_9  = 4'd9;
  localparam logic [3:0] OP_10 = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic opr_legal(input logic [3:0] opr);
    case (opr)
      OP_0, OP_1, OP_2, OP_3, OP_4, OP_6, OP_8, OP_9, OP_10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] opr_maxclk(input logic [3:0] opr);
    case (opr)
      OP_2, OP_3:   return 6'd2;
      OP_4:         return 6'd6;
      OP_6:         return 6'd4;
      OP_9, OP_10:  return 6'd38;
      default:      return 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bank, ALU and control signals of the instruction sequencer.
// master = sequencer side, slave = bank/ALU/controller side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic                        start;
  logic                        hold;
  logic [ADDR_W-1:0]           i;
  logic [instr_pkg::WORD_W-1:0] word;
  logic [63:0]                 operand;
  logic [3:0]                  opr;
  logic                        issue;
  logic                        enrega;
  logic                        enregb;
  logic                        cnsta;
  logic                        cnstb;
  logic [1:0]                  endwreg;
  logic                        wr_en;
  logic                        busy;
  logic                        done;
  logic                        error;

  modport master (
    input  start, hold, word,
    output i, operand, opr, issue, enrega, enregb, cnsta, cnstb, endwreg,
           wr_en, busy, done, error
  );

  modport slave (
    output start, hold, word,
    input  i, operand, opr, issue, enrega, enregb, cnsta, cnstb, endwreg,
           wr_en, busy, done, error
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational split of a bank word, opcode legality and effective wait budget (0 cycles, no state).
// MAXCLK_CHECK_EN: replace a maxclock that disagrees with the opcode table and flag it.
module instr_decode
  import instr_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [63:0]       operand,
  output logic [3:0]        opr,
  output logic [1:0]        endwreg,
  output logic              enrega,
  output logic              enregb,
  output logic              cnsta,
  output logic              cnstb,
  output logic              legal,
  output logic [5:0]        maxclk,
  output logic              maxclk_err
);
  word_t w;

  assign w       = word;
  assign operand = w.operand;
  assign opr     = w.opr;
  assign endwreg = w.endwreg;
  assign enrega  = w.enrega;
  assign enregb  = w.enregb;
  assign cnsta   = w.cnsta;
  assign cnstb   = w.cnstb;
  assign legal   = opr_legal(w.opr);

`ifdef MAXCLK_CHECK_EN
  logic [5:0] tbl_clk;
  assign tbl_clk    = opr_maxclk(w.opr);
  assign maxclk_err = legal && (w.maxclock != tbl_clk);
  assign maxclk     = maxclk_err ? tbl_clk : w.maxclock;
`else
  assign maxclk_err = 1'b0;
  // A zero budget would never reach the commit cycle; run it as one cycle.
  assign maxclk     = (w.maxclock == 6'd0) ? 6'd1 : w.maxclock;
`endif

endmodule

// File: rtl/instr_sequencer.sv
// Runs bank words START_ADDR..LAST_ADDR once per start: FETCH, ISSUE, then maxclock WAIT cycles (period maxclock+2).
// hold stalls FETCH without sampling; optional MAXCLK_CHECK_EN enforces the opcode clock table.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 15
) (
  input  logic              clock,
  input  logic              reset,
  instr_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] START_I = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [63:0]       operand_q, operand_d;
  logic [3:0]        opr_q, opr_d;
  logic [1:0]        endwreg_q, endwreg_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              cnsta_q, cnsta_d, cnstb_q, cnstb_d;
  logic              issue_q, issue_d, enrega_q, enrega_d, enregb_q, enregb_d;
  logic              wr_en_q, wr_en_d, done_q, done_d, busy_q, busy_d, error_q, error_d;

  logic [63:0] dec_operand;
  logic [3:0]  dec_opr;
  logic [1:0]  dec_endwreg;
  logic [5:0]  dec_maxclk;
  logic        dec_enrega, dec_enregb, dec_cnsta, dec_cnstb, dec_legal, dec_mc_err;

  instr_decode u_decode (
    .word       (bus.word),
    .operand    (dec_operand),
    .opr        (dec_opr),
    .endwreg    (dec_endwreg),
    .enrega     (dec_enrega),
    .enregb     (dec_enregb),
    .cnsta      (dec_cnsta),
    .cnstb      (dec_cnstb),
    .legal      (dec_legal),
    .maxclk     (dec_maxclk),
    .maxclk_err (dec_mc_err)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    operand_d = operand_q;
    opr_d     = opr_q;
    endwreg_d = endwreg_q;
    cnsta_d   = cnsta_q;
    cnstb_d   = cnstb_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    issue_d   = 1'b0;
    enrega_d  = 1'b0;
    enregb_d  = 1'b0;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          i_d     = START_I;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (!bus.hold) begin
          if (dec_legal) begin
            state_d   = S_ISSUE;
            issue_d   = 1'b1;
            enrega_d  = dec_enrega;
            enregb_d  = dec_enregb;
            operand_d = dec_operand;
            opr_d     = dec_opr;
            endwreg_d = dec_endwreg;
            cnsta_d   = dec_cnsta;
            cnstb_d   = dec_cnstb;
            cnt_d     = dec_maxclk;
            if (dec_mc_err) error_d = 1'b1;
          end else begin
            // Illegal word: skip straight to the advance/finish decision.
            error_d = 1'b1;
            if (i_q == LAST_I) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wr_en_d = (cnt_q == 6'd1);
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 6'd1;
        wr_en_d = (cnt_q == 6'd2);
        if (cnt_q == 6'd1) begin
          if (i_q == LAST_I) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            i_d     = i_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        i_d       = START_I;
        operand_d = '0;
        opr_d     = '0;
        endwreg_d = '0;
        cnsta_d   = 1'b0;
        cnstb_d   = 1'b0;
        cnt_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= START_I;
      operand_q <= '0;
      opr_q     <= '0;
      endwreg_q <= '0;
      cnsta_q   <= 1'b0;
      cnstb_q   <= 1'b0;
      cnt_q     <= '0;
      issue_q   <= 1'b0;
      enrega_q  <= 1'b0;
      enregb_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      operand_q <= operand_d;
      opr_q     <= opr_d;
      endwreg_q <= endwreg_d;
      cnsta_q   <= cnsta_d;
      cnstb_q   <= cnstb_d;
      cnt_q     <= cnt_d;
      issue_q   <= issue_d;
      enrega_q  <= enrega_d;
      enregb_q  <= enregb_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  assign bus.i       = i_q;
  assign bus.operand = operand_q;
  assign bus.opr     = opr_q;
  assign bus.endwreg = endwreg_q;
  assign bus.cnsta   = cnsta_q;
  assign bus.cnstb   = cnstb_q;
  assign bus.issue   = issue_q;
  assign bus.enrega  = enrega_q;
  assign bus.enregb  = enregb_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.error   = error_q;

endmodule
